// File: rtl/exu_pkg.sv
// Shared definitions for the execution-unit issuer: op-select bit positions,
// writeback exception codes and the issuer FSM state encoding.
package exu_pkg;
    localparam int SIG_W     = 20;

    localparam int OP_MUL    = 0;
    localparam int OP_MULH   = 1;
    localparam int OP_MULHSU = 2;
    localparam int OP_MULHU  = 3;
    localparam int OP_DIV    = 4;
    localparam int OP_DIVU   = 5;
    localparam int OP_REM    = 6;
    localparam int OP_REMU   = 7;
    localparam int OP_FADD   = 8;
    localparam int OP_FSUB   = 9;
    localparam int OP_FMUL   = 10;
    localparam int OP_FDIV   = 11;
    localparam int OP_FSQRT  = 12;
    localparam int OP_FMIN   = 13;
    localparam int OP_FMAX   = 14;
    localparam int OP_FSGNJ  = 15;
    localparam int OP_FSGNJN = 16;
    localparam int OP_LAST   = OP_FSGNJN;

    localparam logic [2:0] EXC_NONE    = 3'd0;
    localparam logic [2:0] EXC_ILLEGAL = 3'd6;
    localparam logic [2:0] EXC_TIMEOUT = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_RESP
    } state_t;
endpackage

// File: rtl/exu_sig_check.sv
// Op-select legality: exactly one defined op bit set, reserved bits clear.
module exu_sig_check
    import exu_pkg::*;
(
    input  logic [SIG_W-1:0] i_sig,
    output logic             o_legal
);
    localparam int OW = OP_LAST + 1;

    logic [OW-1:0] w_ops;
    logic          w_rsvd_clr;
    logic          w_one_hot;

    assign w_ops      = i_sig[OW-1:0];
    assign w_rsvd_clr = (i_sig[SIG_W-1:OW] == '0);
    // clearing the lowest set bit leaves nothing only for a single set bit
    assign w_one_hot  = (w_ops != '0) && ((w_ops & (w_ops - OW'(1))) == '0);
    assign o_legal    = w_rsvd_clr && w_one_hot;
endmodule

// File: rtl/exu_issuer.sv
// Single-op issuer between the core and a variable-latency execution unit,
// with illegal-op rejection, flush/drain handling and a response timeout.
module exu_issuer
    import exu_pkg::*;
#(
    parameter int TIMEOUT = 100
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SIG_W-1:0] req_sig,
    input  logic [31:0]      req_src1,
    input  logic [31:0]      req_src2,
    input  logic [5:0]       req_rd,
    input  logic             flush,
    output logic [SIG_W-1:0] ex_sig,
    output logic [31:0]      ex_src1,
    output logic [31:0]      ex_src2,
    output logic             ex_out_valid,
    input  logic [31:0]      ex_result,
    input  logic [2:0]       ex_exception,
    input  logic             ex_in_valid,
    output logic             wb_valid,
    output logic [5:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic [2:0]       wb_exception,
    output logic [7:0]       stray_cnt
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t           r_state, w_next;
    logic [SIG_W-1:0] r_sig;
    logic [31:0]      r_src1, r_src2, r_wb_data;
    logic [5:0]       r_rd, r_wb_rd;
    logic [2:0]       r_wb_exc;
    logic [CW-1:0]    r_cnt;
    logic [7:0]       r_stray;

    logic             w_legal, w_accept, w_timeout;
    logic             w_cnt_clr, w_cnt_inc, w_wb_load, w_stray;
    logic [31:0]      w_wb_data;
    logic [2:0]       w_wb_exc;
    logic [5:0]       w_wb_rd;

    exu_sig_check u_sig_check (
        .i_sig   (req_sig),
        .o_legal (w_legal)
    );

    assign w_timeout    = (r_cnt >= CW'(TIMEOUT - 1));
    assign ex_sig       = r_sig;
    assign ex_src1      = r_src1;
    assign ex_src2      = r_src2;
    assign wb_rd        = r_wb_rd;
    assign wb_data      = r_wb_data;
    assign wb_exception = r_wb_exc;
    assign stray_cnt    = r_stray;

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_wb_load    = 1'b0;
        w_wb_data    = '0;
        w_wb_exc     = EXC_NONE;
        w_wb_rd      = r_rd;
        w_stray      = 1'b0;
        req_ready    = 1'b0;
        ex_out_valid = 1'b0;
        wb_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = !flush;
                w_stray   = ex_in_valid;
                w_accept  = req_valid && !flush;
                if (w_accept) begin
                    if (w_legal) begin
                        w_next = S_ISSUE;
                    end else begin
                        w_next    = S_RESP;
                        w_wb_load = 1'b1;
                        w_wb_exc  = EXC_ILLEGAL;
                        w_wb_rd   = req_rd;
                    end
                end
            end
            S_ISSUE: begin
                ex_out_valid = 1'b1;
                w_stray      = ex_in_valid;
                w_cnt_clr    = 1'b1;
                w_next       = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                // a flush kills the op even when the result lands the same cycle
                if (ex_in_valid && flush) begin
                    w_next = S_IDLE;
                end else if (ex_in_valid) begin
                    w_next    = S_RESP;
                    w_wb_load = 1'b1;
                    w_wb_data = ex_result;
                    w_wb_exc  = ex_exception;
                end else if (flush) begin
                    w_next    = S_DRAIN;
                    w_cnt_inc = 1'b1;
                end else if (w_timeout) begin
                    w_next    = S_RESP;
                    w_wb_load = 1'b1;
                    w_wb_exc  = EXC_TIMEOUT;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_DRAIN: begin
                if (ex_in_valid || w_timeout) w_next = S_IDLE;
                else                          w_cnt_inc = 1'b1;
            end
            S_RESP: begin
                wb_valid = 1'b1;
                w_stray  = ex_in_valid;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sig     <= '0;
            r_src1    <= '0;
            r_src2    <= '0;
            r_rd      <= '0;
            r_cnt     <= '0;
            r_wb_data <= '0;
            r_wb_exc  <= EXC_NONE;
            r_wb_rd   <= '0;
            r_stray   <= '0;
        end else begin
            if (w_accept) begin
                r_sig  <= req_sig;
                r_src1 <= req_src1;
                r_src2 <= req_src2;
                r_rd   <= req_rd;
            end
            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + CW'(1);
            if (w_wb_load) begin
                r_wb_data <= w_wb_data;
                r_wb_exc  <= w_wb_exc;
                r_wb_rd   <= w_wb_rd;
            end
            if (w_stray && (r_stray != 8'hFF)) r_stray <= r_stray + 8'd1;
        end
    end
endmodule

// File: doc/exu_issuer.md
EXU_ISSUER -- requirements
Module: exu_issuer

Interface
REQ-001 Parameter: TIMEOUT, 100, maximum cycles spent in WAIT/DRAIN before the issuer gives up on the execution unit.
REQ-002 clk  input  1  clock; all logic on posedge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  core has an op to issue.
REQ-005 req_ready  output  1  issuer accepts an op this cycle.
REQ-006 req_sig  input  20  one-hot op select: bit0 mul .. bit16 fsgnjn; bits 19:17 reserved.
REQ-007 req_src1, req_src2  input  32 each  operands.
REQ-008 req_rd  input  6  destination tag, returned with the result.
REQ-009 flush  input  1  kill the in-flight op.
REQ-010 ex_sig  output  20  op select to the execution unit.
REQ-011 ex_src1, ex_src2  output  32 each  operands to the execution unit.
REQ-012 ex_out_valid  output  1  single-cycle issue strobe.
REQ-013 ex_result  input  32  result from the execution unit.
REQ-014 ex_exception  input  3  exception code from the execution unit.
REQ-015 ex_in_valid  input  1  single-cycle completion strobe.
REQ-016 wb_valid  output  1  single-cycle writeback strobe.
REQ-017 wb_rd  output  6  destination tag.
REQ-018 wb_data  output  32  result.
REQ-019 wb_exception  output  3  exception code.
REQ-020 stray_cnt  output  8  count of ignored ex_in_valid pulses; saturates at 255.

Function
REQ-021 States: IDLE, ISSUE, WAIT, DRAIN, RESP.
REQ-022 req_ready shall be 1 only in IDLE with flush=0; an op is accepted when req_valid and req_ready are both 1.
REQ-023 On acceptance the issuer shall latch sig, src1, src2 and rd into internal registers.
REQ-024 A legal op has exactly one of req_sig[16:0] set and req_sig[19:17]=0.
REQ-025 Legal op, accepted in cycle N: go to ISSUE, with ex_out_valid=1 in cycle N+1 only; ex_sig/ex_src1/ex_src2 shall hold the latched values from N+1 until the next acceptance.
REQ-026 Illegal op: go to RESP without issuing; wb_valid=1 in N+1, wb_exception=3'b110, wb_data=0.
REQ-027 ISSUE shall transition to WAIT unconditionally after one cycle, or to DRAIN if flush=1 in that cycle; the strobe is never retracted.
REQ-028 WAIT: a cycle counter shall clear on entry and increment each cycle.
REQ-029 WAIT exit on ex_in_valid=1: capture ex_result/ex_exception and go to RESP, so wb_valid=1 in the next cycle.
REQ-030 WAIT exit on timeout (counter = TIMEOUT-1 with ex_in_valid=0): go to RESP with wb_exception=3'b111 and wb_data=0.
REQ-031 WAIT with flush=1 and ex_in_valid=0: go to DRAIN, keeping the counter running.
REQ-032 WAIT with flush=1 and ex_in_valid=1 in the same cycle: the result is dropped and the next state is IDLE; no wb.
REQ-033 DRAIN: the first ex_in_valid or the timeout shall return the FSM to IDLE with no wb.
REQ-034 RESP lasts exactly one cycle, with wb_valid=1 and wb_rd equal to the latched rd; flush in RESP shall not suppress it; next state is IDLE.
REQ-035 ex_in_valid in IDLE, ISSUE or RESP shall be ignored and shall increment stray_cnt.
REQ-036 wb_valid and ex_out_valid shall never be 1 for two consecutive cycles; at most one op is in flight.
REQ-037 wb_data/wb_exception/wb_rd shall hold their values after wb_valid falls.

Reset
REQ-038 rstn=0 at a posedge: state=IDLE, ex_out_valid=0, wb_valid=0, stray_cnt=0.
REQ-039 rstn=0 at a posedge: ex_sig=0, ex_src=0, wb_data=0, wb_rd=0, wb_exception=0, counter=0.
REQ-040 Reset mid-op shall abandon the op silently; a later ex_in_valid counts as stray.

Structure
REQ-041 Shared package exu_pkg shall hold: op-bit indices 0..16, exception codes EXC_NONE=0, EXC_ILLEGAL=6, EXC_TIMEOUT=7, and the FSM state enum.
REQ-042 The legality check shall be a combinational sub-module exu_sig_check (20-bit in, legal out).

Verification
REQ-043 Legal mul (sig=0x00001, rd=5), EU answers 5 cycles after the strobe with 0x12345678 -> one ex_out_valid pulse; wb_valid 1 cycle after ex_in_valid, wb_rd=5, wb_data=0x12345678, wb_exception=0.
REQ-044 sig=0x00003 or sig=0 -> no ex_out_valid; wb_valid next cycle with exception 6; req_ready=1 again one cycle later.
REQ-045 Legal fdiv, EU silent -> wb_valid with exception 7 exactly TIMEOUT cycles after WAIT entry; a late ex_in_valid gives stray_cnt=1.
REQ-046 flush in WAIT, EU responds 3 cycles later -> no wb_valid; req_ready=0 until DRAIN ends, then 1.
REQ-047 Back-to-back requests with req_valid held high -> the second is accepted only after RESP; all tags returned in order.
REQ-048 rstn asserted in WAIT -> all outputs at reset values next cycle; a subsequent ex_in_valid increments stray_cnt.
